// File: rtl/rtc_week_calendar.sv
// Free-running time base: prescaled seconds/minutes/hours/day/week counters
// with validated runtime load, alarm capture/fire, carry pulses and 12/24-hour display.
module rtc_week_calendar #(
    parameter int CLK_DIV       = 1,
    parameter int DAYS_PER_WEEK = 7,
    parameter int WEEK_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              load,
    input  logic [5:0]        ld_s,
    input  logic [5:0]        ld_m,
    input  logic [4:0]        ld_h,
    input  logic [2:0]        ld_d,
    input  logic [WEEK_W-1:0] ld_w,
    input  logic              mode12,
    input  logic              al_set,
    input  logic [4:0]        al_h,
    input  logic [5:0]        al_m,
    input  logic              al_en,
    output logic [5:0]        s,
    output logic [5:0]        m,
    output logic [4:0]        h,
    output logic [4:0]        h_disp,
    output logic              pm,
    output logic [2:0]        d,
    output logic [WEEK_W-1:0] w,
    output logic              sec_tick,
    output logic              week_wrap,
    output logic              alarm,
    output logic              load_err
);

    localparam int                PS_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PS_W-1:0]   PS_MAX = PS_W'(CLK_DIV - 1);
    localparam logic [3:0]        DPW    = 4'(DAYS_PER_WEEK);
    localparam logic [WEEK_W-1:0] W_MAX  = {WEEK_W{1'b1}};

    function automatic logic hm_ok(input logic [4:0] hr, input logic [5:0] mn);
        return (hr < 5'd24) && (mn < 6'd60);
    endfunction

    logic [PS_W-1:0]   ps_r, ps_nx;
    logic [5:0]        s_r, s_nx, m_r, m_nx;
    logic [4:0]        h_r, h_nx;
    logic [2:0]        d_r, d_nx;
    logic [WEEK_W-1:0] w_r, w_nx;
    logic [4:0]        al_h_r, al_h_nx;
    logic [5:0]        al_m_r, al_m_nx;
    logic              al_valid_r, al_valid_nx;
    logic              sec_tick_r, sec_tick_nx;
    logic              week_wrap_r, week_wrap_nx;
    logic              alarm_r, alarm_nx;
    logic              load_err_r, load_err_nx;

    logic tick_s, ld_ok_s, ld_acc_s, al_ok_s;
    logic c_m_s, c_h_s, c_d_s, c_w_s, c_x_s;

    assign tick_s   = run && (ps_r == PS_MAX);
    assign ld_ok_s  = hm_ok(ld_h, ld_m) && (ld_s < 6'd60) && ({1'b0, ld_d} < DPW);
    assign ld_acc_s = load && ld_ok_s;
    assign al_ok_s  = hm_ok(al_h, al_m);

    // Carry chain: each stage advances only when every lower field is at its maximum.
    assign c_m_s = (s_r == 6'd59);
    assign c_h_s = c_m_s && (m_r == 6'd59);
    assign c_d_s = c_h_s && (h_r == 5'd23);
    assign c_w_s = c_d_s && ({1'b0, d_r} == (DPW - 4'd1));
    assign c_x_s = c_w_s && (w_r == W_MAX);

    // Next-state: load beats tick; pulses are computed so they line up with the new time.
    always_comb begin
        ps_nx        = ps_r;
        s_nx         = s_r;
        m_nx         = m_r;
        h_nx         = h_r;
        d_nx         = d_r;
        w_nx         = w_r;
        sec_tick_nx  = 1'b0;
        week_wrap_nx = 1'b0;
        alarm_nx     = 1'b0;
        if (ld_acc_s) begin
            ps_nx = '0;
            s_nx  = ld_s;
            m_nx  = ld_m;
            h_nx  = ld_h;
            d_nx  = ld_d;
            w_nx  = ld_w;
        end else if (tick_s) begin
            ps_nx        = '0;
            s_nx         = c_m_s ? 6'd0 : s_r + 6'd1;
            m_nx         = c_h_s ? 6'd0 : (c_m_s ? m_r + 6'd1 : m_r);
            h_nx         = c_d_s ? 5'd0 : (c_h_s ? h_r + 5'd1 : h_r);
            d_nx         = c_w_s ? 3'd0 : (c_d_s ? d_r + 3'd1 : d_r);
            w_nx         = c_x_s ? '0 : (c_w_s ? w_r + 1'b1 : w_r);
            sec_tick_nx  = 1'b1;
            week_wrap_nx = c_x_s;
            alarm_nx     = al_en && al_valid_r && c_m_s
                           && (m_nx == al_m_r) && (h_nx == al_h_r);
        end else if (run) begin
            ps_nx = ps_r + 1'b1;
        end else begin
            ps_nx = ps_r;
        end
    end

    // Alarm capture and rejected-request flag.
    always_comb begin
        al_h_nx     = al_h_r;
        al_m_nx     = al_m_r;
        al_valid_nx = al_valid_r;
        if (al_set && al_ok_s) begin
            al_h_nx     = al_h;
            al_m_nx     = al_m;
            al_valid_nx = 1'b1;
        end else begin
            al_valid_nx = al_valid_r;
        end
        load_err_nx = (load && !ld_ok_s) || (al_set && !al_ok_s);
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_r        <= '0;
            s_r         <= 6'd0;
            m_r         <= 6'd0;
            h_r         <= 5'd0;
            d_r         <= 3'd0;
            w_r         <= '0;
            al_h_r      <= 5'd0;
            al_m_r      <= 6'd0;
            al_valid_r  <= 1'b0;
            sec_tick_r  <= 1'b0;
            week_wrap_r <= 1'b0;
            alarm_r     <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            ps_r        <= ps_nx;
            s_r         <= s_nx;
            m_r         <= m_nx;
            h_r         <= h_nx;
            d_r         <= d_nx;
            w_r         <= w_nx;
            al_h_r      <= al_h_nx;
            al_m_r      <= al_m_nx;
            al_valid_r  <= al_valid_nx;
            sec_tick_r  <= sec_tick_nx;
            week_wrap_r <= week_wrap_nx;
            alarm_r     <= alarm_nx;
            load_err_r  <= load_err_nx;
        end
    end

    // 12-hour display mapping: midnight and noon show as 12.
    always_comb begin
        h_disp = h_r;
        pm     = 1'b0;
        if (!mode12) begin
            h_disp = h_r;
            pm     = 1'b0;
        end else if (h_r == 5'd0) begin
            h_disp = 5'd12;
            pm     = 1'b0;
        end else if (h_r < 5'd12) begin
            h_disp = h_r;
            pm     = 1'b0;
        end else if (h_r == 5'd12) begin
            h_disp = 5'd12;
            pm     = 1'b1;
        end else begin
            h_disp = h_r - 5'd12;
            pm     = 1'b1;
        end
    end

    assign s         = s_r;
    assign m         = m_r;
    assign h         = h_r;
    assign d         = d_r;
    assign w         = w_r;
    assign sec_tick  = sec_tick_r;
    assign week_wrap = week_wrap_r;
    assign alarm     = alarm_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_rtc_week_calendar.sv
// Bench for rtc_week_calendar: directed scenarios plus random traffic, checked
// against a model that keeps time as a single running count of seconds.
`timescale 1ns/1ps
module tb_rtc_week_calendar;

    localparam int CLK_DIV = 4;
    localparam int DPW     = 7;
    localparam int WEEK_W  = 8;
    localparam longint DAY_S  = 86400;
    localparam longint WEEK_S = DAY_S * DPW;
    localparam longint PERIOD = WEEK_S * (1 << WEEK_W);

    logic clk = 1'b0, rst = 1'b0, run = 1'b0, load = 1'b0, mode12 = 1'b0;
    logic al_set = 1'b0, al_en = 1'b0;
    logic [5:0] ld_s = 6'd0, ld_m = 6'd0, al_m = 6'd0;
    logic [4:0] ld_h = 5'd0, al_h = 5'd0;
    logic [2:0] ld_d = 3'd0;
    logic [WEEK_W-1:0] ld_w = '0;
    logic [5:0] s, m;
    logic [4:0] h, h_disp;
    logic pm, sec_tick, week_wrap, alarm, load_err;
    logic [2:0] d;
    logic [WEEK_W-1:0] w;

    rtc_week_calendar #(.CLK_DIV(CLK_DIV), .DAYS_PER_WEEK(DPW), .WEEK_W(WEEK_W)) dut (
        .clk(clk), .rst(rst), .run(run), .load(load),
        .ld_s(ld_s), .ld_m(ld_m), .ld_h(ld_h), .ld_d(ld_d), .ld_w(ld_w),
        .mode12(mode12), .al_set(al_set), .al_h(al_h), .al_m(al_m), .al_en(al_en),
        .s(s), .m(m), .h(h), .h_disp(h_disp), .pm(pm), .d(d), .w(w),
        .sec_tick(sec_tick), .week_wrap(week_wrap), .alarm(alarm), .load_err(load_err)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, hits = 0;
    longint t = 0;
    int mpc = 0, m_alh = 0, m_alm = 0;
    bit m_alv = 0, e_tick = 0, e_wrap = 0, e_alarm = 0, e_err = 0;

    function automatic int f_s(longint x); return int'(x % 60); endfunction
    function automatic int f_m(longint x); return int'((x / 60) % 60); endfunction
    function automatic int f_h(longint x); return int'((x / 3600) % 24); endfunction
    function automatic int f_d(longint x); return int'((x / DAY_S) % DPW); endfunction
    function automatic int f_w(longint x); return int'(x / WEEK_S); endfunction

    function automatic int disp_h(int hr, bit m12);
        if (!m12) return hr;
        return (hr % 12 == 0) ? 12 : hr % 12;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; mpc = 0; m_alv = 0; m_alh = 0; m_alm = 0;
        e_tick = 0; e_wrap = 0; e_alarm = 0; e_err = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        bit tk, ld_ok, al_ok;
        tk    = run && (mpc == CLK_DIV - 1);
        ld_ok = (ld_s < 60) && (ld_m < 60) && (ld_h < 24) && (ld_d < DPW);
        al_ok = (al_h < 24) && (al_m < 60);
        e_err = (load && !ld_ok) || (al_set && !al_ok);
        e_tick = 0; e_wrap = 0; e_alarm = 0;
        if (load && ld_ok) begin
            t = ((((longint'(ld_w) * DPW + ld_d) * 24 + ld_h) * 60 + ld_m) * 60) + ld_s;
            mpc = 0;
        end else if (tk) begin
            t = (t + 1) % PERIOD;
            mpc = 0;
            e_tick = 1;
            e_wrap = (t == 0);
            e_alarm = al_en && m_alv && f_s(t) == 0 && f_m(t) == m_alm && f_h(t) == m_alh;
        end else if (run) begin
            mpc++;
        end
        if (al_set && al_ok) begin
            m_alv = 1; m_alh = al_h; m_alm = al_m;
        end
    endtask

    task automatic check_all();
        check("s", s, f_s(t));
        check("m", m, f_m(t));
        check("h", h, f_h(t));
        check("d", d, f_d(t));
        check("w", w, f_w(t));
        check("h_disp", h_disp, disp_h(f_h(t), mode12));
        check("pm", pm, (mode12 && f_h(t) >= 12) ? 1 : 0);
        check("sec_tick", sec_tick, e_tick);
        check("week_wrap", week_wrap, e_wrap);
        check("alarm", alarm, e_alarm);
        check("load_err", load_err, e_err);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        if (alarm) hits++;
        check_all();
        load = 0; al_set = 0;
    endtask

    task automatic do_load(int hh, int mm, int ss, int dd, int ww);
        ld_h = 5'(hh); ld_m = 6'(mm); ld_s = 6'(ss); ld_d = 3'(dd); ld_w = WEEK_W'(ww);
        load = 1;
        step();
    endtask

    int hv[5] = '{0, 11, 12, 13, 23};
    int hd[5] = '{12, 11, 12, 1, 11};
    int hp[5] = '{0, 0, 1, 1, 1};

    initial begin
        model_reset();
        #2;
        check_all();
        #10 rst = 1;

        // Free run: 60 ticks roll seconds into the minute.
        run = 1;
        for (int i = 0; i < 60 * CLK_DIV; i++) step();
        check("m_after_minute", m, 1);
        check("s_after_minute", s, 0);

        // Full wrap of every field, including the week counter.
        do_load(23, 59, 59, 6, 255);
        for (int i = 0; i < CLK_DIV; i++) step();
        check("wrap_w", w, 0);

        // Rejected load keeps counting; load on a tick edge wins over the tick.
        do_load(1, 2, 60, 3, 4);
        for (int i = 0; i < 2 * CLK_DIV && mpc != CLK_DIV - 1; i++) step();
        do_load(5, 6, 7, 1, 9);
        check("load_tick_no_sec_tick", sec_tick, 0);
        check("load_tick_s", s, 7);

        // Alarm fires once at 07:30:00; not when disabled; not on a direct load.
        al_h = 5'd7; al_m = 6'd30; al_set = 1; al_en = 1;
        step();
        do_load(7, 29, 58, 0, 0);
        hits = 0;
        for (int i = 0; i < 2 * CLK_DIV; i++) step();
        check("alarm_hits_en", hits, 1);
        al_en = 0;
        do_load(7, 29, 58, 0, 0);
        hits = 0;
        for (int i = 0; i < 2 * CLK_DIV; i++) step();
        check("alarm_hits_dis", hits, 0);
        al_en = 1;
        hits = 0;
        do_load(7, 30, 0, 0, 0);
        for (int i = 0; i < 2 * CLK_DIV; i++) step();
        check("alarm_hits_load", hits, 0);

        // Invalid load and invalid al_set together give one load_err pulse.
        al_h = 5'd24; al_set = 1;
        do_load(1, 60, 0, 0, 0);
        step();

        // 12-hour display table.
        mode12 = 1;
        for (int i = 0; i < 5; i++) begin
            do_load(hv[i], 0, 0, 0, 0);
            check("h_disp12", h_disp, hd[i]);
            check("pm12", pm, hp[i]);
        end
        mode12 = 0;

        // Pause mid-prescale, then resume.
        step();
        run = 0;
        for (int i = 0; i < 10; i++) step();
        run = 1;
        for (int i = 0; i < 2 * CLK_DIV; i++) step();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            run    = ($urandom_range(0, 9) != 0);
            mode12 = 1'($urandom);
            al_en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                ld_s = 6'($urandom_range(0, 63)); ld_m = 6'($urandom_range(0, 63));
                ld_h = 5'($urandom_range(0, 25)); ld_d = 3'($urandom_range(0, 7));
                ld_w = WEEK_W'($urandom);
                load = 1;
            end
            if ($urandom_range(0, 29) == 0) begin
                al_h = 5'($urandom_range(0, 25));
                al_m = 6'((f_m(t) + 1) % 60 + (($urandom_range(0, 9) == 0) ? 5 : 0));
                if ($urandom_range(0, 1) == 0) al_h = 5'(f_h(t));
                al_set = 1;
            end
            if ($urandom_range(0, 199) == 0 && f_s(t) > 30) begin
                ld_s = 6'd58; ld_m = 6'($urandom_range(0, 59)); ld_h = 5'($urandom_range(0, 23));
                ld_d = 3'($urandom_range(0, 6)); ld_w = WEEK_W'($urandom);
                load = 1;
            end
            step();
        end

        // Asynchronous reset between clock edges.
        run = 1;
        do_load(13, 45, 12, 3, 77);
        step();
        #2 rst = 0;
        #1;
        model_reset();
        check_all();
        rst = 1;
        for (int i = 0; i < 2 * CLK_DIV; i++) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rtc_week_calendar.md
Name: rtc_week_calendar

Overview:
- Parametrised successor of the seconds/minutes/hours/day/week time counter.
- Adds a clock prescaler, run/pause control, validated runtime load, 12/24-hour display, a single-cycle alarm and carry pulses.
- Sits between the system clock and the display/alarm logic, as the free-running time base.

Parameters:
CLK_DIV, 1, clk cycles per second tick (>=1)
DAYS_PER_WEEK, 7, day-of-week modulus (2..8)
WEEK_W, 8, width of week counter; wraps at 2^WEEK_W-1 -> 0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset (rst=0 resets)
run  in  1  1 = count; 0 = hold all counters and prescaler
load  in  1  single-cycle load strobe
ld_s  in  6  load seconds
ld_m  in  6  load minutes
ld_h  in  5  load hours (24 h)
ld_d  in  3  load day-of-week
ld_w  in  WEEK_W  load week
mode12  in  1  1 = 12-hour display format
al_set  in  1  alarm time capture strobe
al_h  in  5  alarm hour (24 h)
al_m  in  6  alarm minute
al_en  in  1  alarm enable (level)
s  out  6  seconds 0..59
m  out  6  minutes 0..59
h  out  5  hours 0..23
h_disp  out  5  display hours
pm  out  1  PM flag
d  out  3  day-of-week 0..DAYS_PER_WEEK-1
w  out  WEEK_W  week count
sec_tick  out  1  one-cycle pulse per second advance
week_wrap  out  1  one-cycle pulse when w wraps to 0
alarm  out  1  one-cycle alarm pulse
load_err  out  1  one-cycle pulse on rejected load/al_set

Behaviour:
- Reset (rst=0, async):
  - s=m=h=d=w=0 and prescaler=0.
  - Alarm registers are cleared: al_h_r=0, al_m_r=0, al_valid=0.
  - All pulse outputs are 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 only while run=1.
  - tick = run && (prescaler==CLK_DIV-1); prescaler returns to 0 on tick.
  - With CLK_DIV=1, tick = run every cycle.
  - run=0 freezes the prescaler value.
- Cascade on tick, all fields updated on the same edge:
  - s+1. At 59, s->0 and m advances.
  - m at 59 -> 0 and h advances.
  - h at 23 -> 0 and d advances.
  - d at DAYS_PER_WEEK-1 -> 0 and w advances.
  - w at 2^WEEK_W-1 -> 0 and week_wrap=1 for one cycle.
- sec_tick: registered and high for exactly the cycle in which the new s value is visible.
- Load:
  - Valid when ld_s<60, ld_m<60, ld_h<24 and ld_d<DAYS_PER_WEEK.
  - Valid load: all five fields take the ld_* values next edge and the prescaler is cleared to 0.
  - Load has priority over tick in the same cycle; that tick is discarded and sec_tick=0.
  - Invalid load: counters untouched, counting continues normally, load_err=1 for one cycle.
  - A load is accepted regardless of run.
- Alarm capture:
  - al_set with al_h<24 and al_m<60: al_h_r/al_m_r captured and al_valid=1.
  - Invalid al_set: registers unchanged and load_err=1.
  - If load and al_set are both invalid in the same cycle, load_err is a single pulse.
- Alarm fire:
  - alarm=1 for one cycle, coincident with sec_tick, when a tick produces s=0 with m==al_m_r, h==al_h_r, al_en=1 and al_valid=1.
  - A load that lands on the alarm time never fires the alarm.
  - Changing al_en does not affect the time counters.
- Display (combinational from h and mode12):
  - mode12=0: h_disp=h, pm=0.
  - mode12=1: h=0 -> h_disp=12, pm=0; h 1..11 -> h_disp=h, pm=0; h=12 -> h_disp=12, pm=1; h 13..23 -> h_disp=h-12, pm=1.
- Reset mid-operation: all state clears immediately, without waiting for a clock edge; counting resumes from 0 on the first edge after rst returns to 1, subject to run.
- Outputs never hold out-of-range values.

Test Plan:
- CLK_DIV=4, run=1 from reset -> sec_tick every 4th cycle; s reaches 59 then 0 while m goes 0->1 on the same edge.
- Load 23:59:59, d=6, w=255 (WEEK_W=8), then 1 tick -> s=m=h=d=w=0 and week_wrap=1 for one cycle.
- Load ld_s=60 -> load_err pulses once and counters continue unchanged; load in the same cycle as a tick -> loaded values appear and no sec_tick.
- al_set 07:30, al_en=1, load 07:29:58, 2 ticks -> alarm=1 in the cycle s=0 (07:30:00) only; repeat with al_en=0 -> no alarm; load 07:30:00 directly -> no alarm.
- mode12=1 at h=0, 11, 12, 13, 23 -> h_disp/pm = 12/0, 11/0, 12/1, 1/1, 11/1.
- run=0 mid-prescale for 10 cycles -> all outputs and prescaler frozen; rst=0 asynchronously mid-count -> all outputs 0 before the next clk edge.
